// File: rtl/addsub_multicycle.sv
// Slice-serial adder/subtractor: SLICE bits per cycle over WIDTH/SLICE cycles, Start/Busy/Done.
// Optional early exit in add mode when the remaining operand slices and carry are zero: ADDSUB_EARLY_EXIT_EN.
module addsub_multicycle #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic             Sub,
  input  logic             Cin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero
);

  localparam int unsigned NSL = WIDTH / SLICE;
  localparam int unsigned CW  = $clog2(NSL) + 1;
  localparam logic [CW-1:0] NslCnt  = CW'(NSL);
  localparam logic [CW-1:0] LastCnt = CW'(NSL - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, busy_q, done_q, cout_q, ovf_q, zero_q;

  int unsigned      base;
  logic [SLICE-1:0] a_sl, b_sl;
  logic [SLICE:0]   sl_res;
  logic [WIDTH-1:0] sum_d;
  logic             last_sl, msb_cin, early_exit;

  always_comb begin
    base = 0;
    // Counter sits at NSL in DONE; keep the slice select in range there.
    if (cnt_q < NslCnt) base = 32'(cnt_q) * SLICE;
    a_sl    = a_q[base +: SLICE];
    b_sl    = b_q[base +: SLICE];
    sl_res  = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};
    msb_cin = a_sl[SLICE-1] ^ b_sl[SLICE-1] ^ sl_res[SLICE-1];
    last_sl = (cnt_q == LastCnt);
    sum_d   = sum_q;
    sum_d[base +: SLICE] = sl_res[SLICE-1:0];
  end

`ifdef ADDSUB_EARLY_EXIT_EN
  logic sub_q;
  logic rest_zero;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sub_q <= 1'b0;
    end else if (Start && (state_q != StRun)) begin
      sub_q <= Sub;
    end
  end

  always_comb begin
    rest_zero  = (((a_q | b_q) >> (base + SLICE)) == '0);
    early_exit = !sub_q && !sl_res[SLICE] && rest_zero && !last_sl;
  end
`else
  assign early_exit = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          if (Start) begin
            a_q     <= A;
            b_q     <= Sub ? ~B : B;
            carry_q <= Sub | Cin;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end else begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StRun: begin
          sum_q   <= sum_d;
          carry_q <= sl_res[SLICE];
          cnt_q   <= cnt_q + CW'(1);
          if (last_sl || early_exit) begin
            // An early exit leaves no carry pending, so Cout/Ovf stay 0.
            cout_q  <= last_sl & sl_res[SLICE];
            ovf_q   <= last_sl & (msb_cin ^ sl_res[SLICE]);
            zero_q  <= (sum_d == '0);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;
  assign Zero = zero_q;

endmodule

// File: tb/tb_addsub_multicycle.sv
// Table-driven bench for addsub_multicycle with a scoreboard queue of expected results.
module tb_addsub_multicycle;

  localparam int unsigned W  = 16;
  localparam int unsigned SL = 4;
  localparam int unsigned NS = W / SL;
`ifdef ADDSUB_EARLY_EXIT_EN
  localparam bit EarlyEn = 1'b1;
`else
  localparam bit EarlyEn = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RST, Start, Sub, Cin;
  logic [W-1:0] A, B, Sum;
  logic         Busy, Done, Cout, Ovf, Zero;

  typedef struct {
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         b2b;
    logic         poke;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    int           lat;
  } exp_t;

  localparam int NV = 11;
  vec_t         vecs[NV];
  exp_t         sb[$];
  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] last_sum;
  logic         last_zero;

  addsub_multicycle #(.WIDTH(W), .SLICE(SL)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .Start(Start),
    .Sub  (Sub),
    .Cin  (Cin),
    .A    (A),
    .B    (B),
    .Busy (Busy),
    .Done (Done),
    .Sum  (Sum),
    .Cout (Cout),
    .Ovf  (Ovf),
    .Zero (Zero)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Number of RUN edges until Done for a given operation.
  function automatic int exp_lat(input logic s, input logic c, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    logic          cy;
    logic [SL:0]   r;
    logic [W-1:0]  a_sh, b_sh;
    if (s || !EarlyEn) return NS;
    cy = c;
    for (int k = 0; k < NS; k++) begin
      a_sh = a >> (k * SL);
      b_sh = b >> (k * SL);
      r    = {1'b0, a_sh[SL-1:0]} + {1'b0, b_sh[SL-1:0]} + {{SL{1'b0}}, cy};
      cy   = r[SL];
      if (k < NS - 1 && !cy && (((a | b) >> ((k + 1) * SL)) == '0)) return k + 1;
    end
    return NS;
  endfunction

  task automatic launch(input vec_t v);
    exp_t e;
    e.sum  = v.sum;
    e.cout = v.cout;
    e.ovf  = v.ovf;
    e.zero = v.zero;
    e.lat  = exp_lat(v.sub, v.cin, v.a, v.b);
    sb.push_back(e);
    Sub   = v.sub;
    Cin   = v.cin;
    A     = v.a;
    B     = v.b;
    Start = 1'b1;
  endtask

  // Waits for Done (bounded), optionally poking Start during RUN cycles 2 and 3.
  task automatic collect(input string name, input bit poke);
    exp_t e;
    int   k;
    bit   seen;
    @(posedge CLK); #1;
    Start = 1'b0;
    check({name, " busy"}, 32'(Busy), 32'd1);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 4 * NS) begin
      @(posedge CLK); #1;
      k++;
      if (Done) seen = 1'b1;
      else if (poke && k < 3) begin
        Start = 1'b1;
        A     = 16'hAAAA;
        B     = 16'h5555;
        Sub   = ~Sub;
      end else Start = 1'b0;
    end
    Start = 1'b0;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: got no Done want Done after %0d edges", name, e.lat);
      return;
    end
    check({name, " latency"}, 32'(k), 32'(e.lat));
    check({name, " sum"}, 32'(Sum), 32'(e.sum));
    check({name, " cout"}, 32'(Cout), 32'(e.cout));
    check({name, " ovf"}, 32'(Ovf), 32'(e.ovf));
    check({name, " zero"}, 32'(Zero), 32'(e.zero));
    check({name, " busy in done"}, 32'(Busy), 32'd0);
    last_sum  = e.sum;
    last_zero = e.zero;
  endtask

  task automatic idle_check(input string name);
    Start = 1'b0;
    @(posedge CLK); #1;
    check({name, " done pulse width"}, 32'(Done), 32'd0);
    check({name, " idle busy"}, 32'(Busy), 32'd0);
    check({name, " sum held"}, 32'(Sum), 32'(last_sum));
    check({name, " zero held"}, 32'(Zero), 32'(last_zero));
  endtask

  initial begin
    vec_t rv;
    bit   rdone;
    //           sub   cin   a         b         b2b   poke  sum       cout  ovf   zero
    vecs[0]  = '{1'b0, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 16'h0003, 16'h0005, 1'b0, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 16'h0003, 16'h0004, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 16'h0005, 16'h0000, 1'b1, 1'b0, 16'h0006, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};

    RST = 1'b1; Start = 1'b0; Sub = 1'b0; Cin = 1'b0; A = '0; B = '0;
    #12;
    check("reset busy", 32'(Busy), 32'd0);
    check("reset done", 32'(Done), 32'd0);
    check("reset sum", 32'(Sum), 32'd0);
    check("reset cout", 32'(Cout), 32'd0);
    check("reset ovf", 32'(Ovf), 32'd0);
    check("reset zero", 32'(Zero), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;

    for (int i = 0; i < NV; i++) begin
      launch(vecs[i]);
      collect($sformatf("v%0d", i), vecs[i].poke);
      if (!(i + 1 < NV && vecs[i + 1].b2b)) idle_check($sformatf("v%0d", i));
    end

    // Asynchronous reset between edges in the middle of an operation.
    rv = '{1'b0, 1'b0, 16'h0111, 16'h0001, 1'b0, 1'b0, 16'h0112, 1'b0, 1'b0, 1'b0};
    launch(rv);
    @(posedge CLK); #1;
    Start = 1'b0;
    @(posedge CLK); #1;
    check("pre-reset busy", 32'(Busy), 32'd1);
    check("pre-reset sum slice", 32'(Sum), 32'h0002);
    #2;
    RST = 1'b1;
    #1;
    check("async reset busy", 32'(Busy), 32'd0);
    check("async reset done", 32'(Done), 32'd0);
    check("async reset sum", 32'(Sum), 32'd0);
    check("async reset cout", 32'(Cout), 32'd0);
    check("async reset ovf", 32'(Ovf), 32'd0);
    check("async reset zero", 32'(Zero), 32'd0);
    sb.delete();
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    rdone = 1'b0;
    for (int k = 0; k < 2 * NS; k++) begin
      @(posedge CLK); #1;
      if (Done) rdone = 1'b1;
    end
    check("no done after reset", 32'(rdone), 32'd0);
    launch(vecs[0]);
    collect("post-reset", 1'b0);
    idle_check("post-reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test want end before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
